// File: rtl/multicycle_control_if.sv
// Instruction/data memory handshake bundle for multicycle_control.
// master = control FSM side, slave = memory side.
interface multicycle_control_if;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ready, imem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ready, imem_rdata, dmem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with wait-state timeout traps.
// Define RV32M_MDU_EN to sequence RV32M ops through an external multi-cycle MDU.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master mem,
  input  logic                 br_cond,
  input  logic                 mdu_done,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic [2:0]           load_ctrl,
  output logic [1:0]           store_ctrl,
  output logic                 mdu_start,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDU    = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state_q, state_d;
  logic [31:0]   ir_q;
  logic [CW-1:0] wait_cnt_q;
  logic          wait_inc;
  logic          trap_q;
  logic [1:0]    cause_q, cause_d;
  logic          timeout_hit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic is_r, is_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic is_mul, r_ok, legal;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7    = ir_q[31:25];
  assign is_r      = (opcode == 7'b0110011);
  assign is_imm    = (opcode == 7'b0010011);
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_branch = (opcode == 7'b1100011);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign is_lui    = (opcode == 7'b0110111);
  assign is_auipc  = (opcode == 7'b0010111);

`ifdef RV32M_MDU_EN
  logic mdu_started_q;
  assign is_mul = (funct7 == 7'b0000001);
`else
  assign is_mul = 1'b0;
`endif

  assign r_ok  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000) || is_mul;
  assign legal = (is_r && r_ok) || is_imm || is_load || is_store || is_branch ||
                 is_jal || is_jalr || is_lui || is_auipc;

  // Trap fires on the TIMEOUT-th consecutive non-ready cycle of a request.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CW'(TIMEOUT - 1));

  function automatic logic [ALUOP_W-1:0] mk_op(input logic alt, input logic [2:0] f3);
    mk_op = '0;
    mk_op[ALUOP_W-1] = alt;
    mk_op[2:0] = f3;
  endfunction

  always_comb begin
    state_d      = state_q;
    cause_d      = 2'b00;
    wait_inc     = 1'b0;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_op       = '0;
    alu_src_a    = 1'b1;
    alu_src_b    = 2'b00;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    load_ctrl    = 3'b111;
    store_ctrl   = 2'b11;
    mdu_start    = 1'b0;
    // Outputs are forced idle while reset is held so an aborted instruction issues nothing.
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem.imem_req = 1'b1;
          if (mem.imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (timeout_hit) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
          end else begin
            wait_inc = 1'b1;
          end
        end
        S_DECODE: begin
          if (legal) state_d = S_EXEC;
          else begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        end
        S_EXEC: begin
          if (is_r) begin
            alu_op  = mk_op(funct7[5], funct3);
            state_d = is_mul ? S_MDU : S_WB;
          end else if (is_imm) begin
            alu_src_b = 2'b10;
            alu_op    = mk_op((funct3 == 3'b101) && funct7[5], funct3);
            state_d   = S_WB;
          end else if (is_load || is_store) begin
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end else if (is_branch) begin
            alu_op   = mk_op(1'b1, funct3);
            pc_write = br_cond;
            pc_src   = 2'b01;
            state_d  = S_FETCH;
          end else if (is_jal) begin
            pc_write = 1'b1;
            pc_src   = 2'b01;
            state_d  = S_WB;
          end else if (is_jalr) begin
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            state_d   = S_WB;
          end else if (is_lui || is_auipc) begin
            alu_src_a = is_lui;
            alu_src_b = 2'b10;
            state_d   = S_WB;
          end else begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        end
        S_MEM: begin
          mem.dmem_req = 1'b1;
          mem.dmem_we  = is_store;
          alu_src_b    = 2'b10;
          if (is_load)  load_ctrl  = funct3;
          if (is_store) store_ctrl = funct3[1:0];
          if (mem.dmem_ready) state_d = is_store ? S_FETCH : S_WB;
          else if (timeout_hit) begin
            state_d = S_TRAP;
            cause_d = 2'b11;
          end else begin
            wait_inc = 1'b1;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          if (is_load) begin
            wb_sel    = 2'b01;
            load_ctrl = funct3;
          end else if (is_jal || is_jalr) wb_sel = 2'b10;
          else if (is_mul)                wb_sel = 2'b11;
          state_d = S_FETCH;
        end
`ifdef RV32M_MDU_EN
        S_MDU: begin
          mdu_start = !mdu_started_q;
          if (mdu_done) state_d = S_WB;
        end
`endif
        S_TRAP: state_d = S_TRAP;
        default: begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      wait_cnt_q <= '0;
      trap_q     <= 1'b0;
      cause_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      if (ir_write) ir_q <= mem.imem_rdata;
      if (state_d != state_q)  wait_cnt_q <= '0;
      else if (wait_inc)       wait_cnt_q <= wait_cnt_q + CW'(1);
      if (state_d == S_TRAP && state_q != S_TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= cause_d;
      end
    end
  end

`ifdef RV32M_MDU_EN
  always_ff @(posedge clk) begin
    if (!rst_n) mdu_started_q <= 1'b0;
    else        mdu_started_q <= (state_q == S_MDU);
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{mdu_done, ir_q[24:15], ir_q[11:7]};

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control; expected per-cycle state paths
// are built from instruction class and memory wait counts, then compared cycle by cycle.
module tb_multicycle_control;
  localparam int unsigned TO = 16;
`ifdef RV32M_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       br_cond, mdu_done;
  logic       ir_write, pc_write, alu_src_a, reg_write, mdu_start, trap;
  logic [1:0] pc_src, alu_src_b, wb_sel, store_ctrl, trap_cause;
  logic [3:0] alu_op;
  logic [2:0] load_ctrl, st;

  multicycle_control_if bus ();

  multicycle_control #(.TIMEOUT(TO), .ALUOP_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (bus),
    .br_cond    (br_cond),
    .mdu_done   (mdu_done),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .load_ctrl  (load_ctrl),
    .store_ctrl (store_ctrl),
    .mdu_start  (mdu_start),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state      (st)
  );

  always #5 clk = ~clk;

  typedef enum int {K_R, K_IMM, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_MUL, K_ILL} kind_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic kind_t classify(input logic [31:0] ins);
    logic [6:0] f7;
    f7 = ins[31:25];
    case (ins[6:0])
      7'h33: begin
        if (f7 == 7'h00 || f7 == 7'h20) classify = K_R;
        else if (f7 == 7'h01 && MDU_EN) classify = K_MUL;
        else classify = K_ILL;
      end
      7'h13:   classify = K_IMM;
      7'h03:   classify = K_LOAD;
      7'h23:   classify = K_STORE;
      7'h63:   classify = K_BR;
      7'h6F:   classify = K_JAL;
      7'h67:   classify = K_JALR;
      7'h37:   classify = K_LUI;
      7'h17:   classify = K_AUIPC;
      default: classify = K_ILL;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.dmem_ready = 1'b0;
    br_cond = 1'b0; mdu_done = 1'b0;
    @(posedge clk); #4;
    check_eq("rst_state", st, 0);
    check_eq("rst_trap", trap, 0);
    check_eq("rst_cause", trap_cause, 0);
    check_eq("rst_imem_req", bus.imem_req, 0);
    check_eq("rst_dmem_req", bus.dmem_req, 0);
    check_eq("rst_writes", {reg_write, pc_write, ir_write, mdu_start}, 0);
    check_eq("rst_load_ctrl", load_ctrl, 3'b111);
    check_eq("rst_store_ctrl", store_ctrl, 2'b11);
    check_eq("rst_alu", {alu_op, alu_src_a, alu_src_b}, 7'b0000_1_00);
    check_eq("rst_sel", {pc_src, wb_sel}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Drives one instruction from FETCH to its return to FETCH (or to TRAP, then resets).
  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                           input int mw, input logic brc);
    kind_t k;
    int q[$];
    int cause, fi, di, mi, s;
    logic ir, dr, md;
    logic [2:0] f3;
    logic [3:0] e_op;
    logic e_a, e_pcw, chk_op, chk_ab;
    logic [1:0] e_b, e_pcs, e_wb, e_pc_src_now;
    logic e_pcw_now;

    k = classify(ins);
    f3 = ins[14:12];
    cause = 0;
    if (TO > 0 && iw >= int'(TO)) begin
      repeat (TO) q.push_back(0);
      q.push_back(7); cause = 2;
    end else begin
      repeat (iw + 1) q.push_back(0);
      q.push_back(1);
      if (k == K_ILL) begin
        q.push_back(7); cause = 1;
      end else begin
        q.push_back(2);
        if (k == K_LOAD || k == K_STORE) begin
          if (TO > 0 && dw >= int'(TO)) begin
            repeat (TO) q.push_back(3);
            q.push_back(7); cause = 3;
          end else begin
            repeat (dw + 1) q.push_back(3);
            if (k == K_LOAD) q.push_back(4);
          end
        end else if (k == K_MUL) begin
          repeat (mw + 1) q.push_back(5);
          q.push_back(4);
        end else if (k != K_BR) begin
          q.push_back(4);
        end
      end
    end
    if (cause != 0) repeat (4) q.push_back(7);

    // Expected EXEC controls by instruction class.
    e_op = 4'h0; e_a = 1'b1; e_b = 2'b00; e_pcw = 1'b0; e_pcs = 2'b00;
    chk_op = 1'b1; chk_ab = 1'b1;
    case (k)
      K_R, K_MUL:      e_op = {ins[30], f3};
      K_IMM:   begin e_op = {(f3 == 3'b101) && ins[30], f3}; e_b = 2'b10; end
      K_LOAD, K_STORE: e_b = 2'b10;
      K_BR:    begin e_op = {1'b1, f3}; e_pcw = brc; e_pcs = 2'b01; end
      K_JAL:   begin e_pcw = 1'b1; e_pcs = 2'b01; chk_op = 1'b0; chk_ab = 1'b0; end
      K_JALR:  begin e_pcw = 1'b1; e_pcs = 2'b10; chk_op = 1'b0; chk_ab = 1'b0; end
      K_LUI:   begin e_b = 2'b10; chk_op = 1'b0; end
      K_AUIPC: begin e_a = 1'b0; e_b = 2'b10; chk_op = 1'b0; end
      default: ;
    endcase
    e_wb = (k == K_LOAD) ? 2'b01 : (k == K_JAL || k == K_JALR) ? 2'b10 :
           (k == K_MUL) ? 2'b11 : 2'b00;

    fi = 0; di = 0; mi = 0;
    for (int i = 0; i < q.size(); i++) begin
      s  = q[i];
      ir = (s == 0) && (fi == iw);
      dr = (s == 3) && (di == dw);
      md = (s == 5) && (mi == mw);
      bus.imem_ready = ir;
      bus.imem_rdata = ir ? ins : $urandom;
      bus.dmem_ready = dr;
      mdu_done = md;
      br_cond = brc;
      #4;
      check_eq("state", st, s);
      check_eq("imem_req", bus.imem_req, s == 0);
      check_eq("dmem_req", bus.dmem_req, s == 3);
      check_eq("reg_write", reg_write, s == 4);
      check_eq("ir_write", ir_write, ir);
      check_eq("trap", trap, s == 7);
      if (s == 7) check_eq("trap_cause", trap_cause, cause);
      check_eq("mdu_start", mdu_start, (s == 5) && (mi == 0));
      e_pcw_now    = (s == 0) ? ir : (s == 2) ? e_pcw : 1'b0;
      e_pc_src_now = (s == 2) ? e_pcs : 2'b00;
      check_eq("pc_write", pc_write, e_pcw_now);
      if (e_pcw_now) check_eq("pc_src", pc_src, e_pc_src_now);
      check_eq("load_ctrl", load_ctrl, ((s == 3 || s == 4) && k == K_LOAD) ? f3 : 3'b111);
      check_eq("store_ctrl", store_ctrl, (s == 3 && k == K_STORE) ? f3[1:0] : 2'b11);
      if (s == 3) check_eq("dmem_we", bus.dmem_we, k == K_STORE);
      if (s == 2 && chk_op) check_eq("alu_op", alu_op, e_op);
      if (s == 2 && chk_ab) check_eq("alu_src", {alu_src_a, alu_src_b}, {e_a, e_b});
      if (s == 4) check_eq("wb_sel", wb_sel, e_wb);
      if (s == 0) fi++;
      if (s == 3) di++;
      if (s == 5) mi++;
      @(posedge clk); #1;
    end
    if (cause != 0) do_reset();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] bf [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [6:0] io [4] = '{7'h00, 7'h0F, 7'h73, 7'h7F};
    r = $urandom;
    case ($urandom_range(0, 10))
      0: begin r[6:0] = 7'h33; r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
      1: r[6:0] = 7'h13;
      2: begin r[6:0] = 7'h03; r[14:12] = lf[$urandom_range(0, 4)]; end
      3: begin r[6:0] = 7'h23; r[14:12] = 3'($urandom_range(0, 2)); end
      4: begin r[6:0] = 7'h63; r[14:12] = bf[$urandom_range(0, 5)]; end
      5: r[6:0] = 7'h6F;
      6: begin r[6:0] = 7'h67; r[14:12] = 3'd0; end
      7: r[6:0] = 7'h37;
      8: r[6:0] = 7'h17;
      9: begin r[6:0] = 7'h33; r[31:25] = 7'h01; end
      default: begin
        if ($urandom_range(0, 1) != 0) r[6:0] = io[$urandom_range(0, 3)];
        else begin r[6:0] = 7'h33; r[31:25] = 7'h10; end
      end
    endcase
    return r;
  endfunction

  initial begin
    int iw, dw;
    do_reset();
    run_instr(32'h002081B3, 0, 0, 0, 1'b0);            // add, zero wait
    run_instr(32'h0080A283, 0, 3, 0, 1'b0);            // lw, dmem 3 waits
    run_instr(32'h0050A223, 1, 0, 0, 1'b0);            // sw
    run_instr(32'h00000463, 0, 0, 0, 1'b1);            // beq taken
    run_instr(32'h00000463, 0, 0, 0, 1'b0);            // beq not taken
    run_instr(32'h022081B3, 0, 0, 5, 1'b0);            // mul
    run_instr(32'h00000000, 0, 0, 0, 1'b0);            // illegal
    run_instr(32'h002081B3, int'(TO) - 1, 0, 0, 1'b0); // last wait before timeout
    run_instr(32'h002081B3, int'(TO) + 4, 0, 0, 1'b0); // imem timeout
    run_instr(32'h0080A283, 0, int'(TO) - 1, 0, 1'b0);
    run_instr(32'h0080A283, 0, int'(TO), 0, 1'b0);     // dmem timeout
    for (int n = 0; n < 80; n++) begin
      iw = ($urandom_range(0, 19) == 0) ? int'(TO) : $urandom_range(0, 3);
      dw = ($urandom_range(0, 19) == 0) ? int'(TO) : $urandom_range(0, 3);
      run_instr(rand_instr(), iw, dw, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview: Parametrised multi-cycle control FSM for the RV32I core, successor to the single-cycle decoder. It latches each fetched instruction, steps it through FETCH/DECODE/EXEC/MEM/WB, and drives datapath enables. It handshakes with instruction and data memories that may insert wait states, traps on illegal opcodes or bus timeout, and optionally sequences RV32M ops through an external multi-cycle MDU.

Parameters:
TIMEOUT, 16, max wait cycles on imem/dmem handshake before trap; 0 = never time out
ALUOP_W, 4, ALU op width; MSB = alt-op bit (sub/sra/branch compare), low 3 = funct3

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
imem_ready  in  1  imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
dmem_ready  in  1  data access complete this cycle
br_cond  in  1  branch comparator result for current instruction (valid in EXEC)
mdu_done  in  1  MDU result valid (used only with RV32M_MDU_EN)
imem_req  out  1  fetch request
dmem_req  out  1  data access request
dmem_we  out  1  1 = store
ir_write  out  1  latch instruction / pc+4 into pc (one-cycle pulse)
pc_write  out  1  write pc from pc_src
pc_src  out  2  00 pc+4, 01 branch/jal target (pc_q+imm), 10 jalr target (rs1+imm)&~1
alu_op  out  ALUOP_W  ALU operation
alu_src_a  out  1  1 rs1, 0 pc_q
alu_src_b  out  2  00 rs2, 01 const 4, 10 imm
reg_write  out  1  register-file write enable (WB only)
wb_sel  out  2  00 alu, 01 load data, 10 pc_q+4, 11 mdu result
load_ctrl  out  3  funct3 during load MEM/WB, else 3'b111
store_ctrl  out  2  funct3[1:0] during store MEM, else 2'b11
mdu_start  out  1  one-cycle MDU start pulse
trap  out  1  sticky trap flag
trap_cause  out  2  00 none, 01 illegal, 10 imem timeout, 11 dmem timeout
state  out  3  FSM state (debug)

Behaviour:
- Reset: state=FETCH; all enables/requests 0; alu_op 0, alu_src_a 1, alu_src_b 00, pc_src 00, wb_sel 00, load_ctrl 3'b111, store_ctrl 2'b11, trap 0, trap_cause 00, IR 0, wait counter 0. Reset mid-instruction aborts it, no write issued.
- States: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, MDU 5, TRAP 7.
- FETCH: imem_req=1. On imem_ready: IR<=imem_rdata, ir_write=1, pc_write=1 with pc_src 00, go to DECODE. Otherwise wait counter increments; when it reaches TIMEOUT (TIMEOUT>0) -> TRAP, cause 10.
- DECODE: decode the opcode. Illegal opcode, or R-type funct7 not in {0000000, 0100000} with the macro off -> TRAP, cause 01.
- EXEC:
  - R: alu_src_a 1, b 00, alu_op {funct7[5],funct3} -> WB.
  - OP-IMM: b 10, alu_op {funct3==101 & funct7[5], funct3} -> WB.
  - load/store: alu_op 0, b 10 -> MEM.
  - branch: b 00, alu_op {1,funct3}; pc_write=br_cond, pc_src 01 -> FETCH.
  - jal: pc_write, pc_src 01 -> WB. jalr: pc_write, pc_src 10 -> WB.
  - lui: a 1 (datapath forces rs1=x0), b 10 -> WB. auipc: a 0, b 10 -> WB.
- MEM: dmem_req=1, dmem_we=store, load_ctrl/store_ctrl valid. Hold all outputs until dmem_ready. Store -> FETCH; load -> WB. Timeout -> TRAP, cause 11.
- WB: reg_write=1 for exactly one cycle. wb_sel: alu / load 01 / jal,jalr 10 / mdu 11. -> FETCH.
- TRAP: all requests and writes 0; stays until rst_n=0.
- Wait counter clears on every state change. A ready in the same cycle as the request is accepted with zero wait.
- Latency with zero-wait memory: R/I/lui/auipc 4 cycles, load 5, store 4, branch 3, jal/jalr 4.

Optional Feature:
RV32M_MDU_EN defined: R-type with funct7=0000001 goes EXEC -> MDU. mdu_start pulses on MDU entry; MDU waits for mdu_done, then goes to WB with wb_sel 11. No timeout in MDU.
Undefined: funct7=0000001 traps as illegal, and mdu_start is tied to 0.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> state=0, imem_req=1 on the first cycle after release, load_ctrl=3'b111, store_ctrl=2'b11, trap=0.
- Fetch 0x002081B3 (add x3,x1,x2), imem_ready same cycle -> alu_op=0000, alu_src_b=00 in EXEC; reg_write=1 for one cycle at cycle 4; back in FETCH at cycle 5.
- 0x0080A283 (lw x5,8(x1)), dmem_ready delayed 3 cycles -> dmem_req held 4 cycles with load_ctrl=010; then WB with wb_sel=01 and reg_write=1.
- 0x0050A223 (sw) -> MEM with dmem_we=1, store_ctrl=10, reg_write never 1. 0x00000463 (beq) with br_cond=1 -> pc_write with pc_src=01 in EXEC; with br_cond=0 -> no EXEC pc_write.
- imem_rdata=0x00000000 -> TRAP, trap_cause=01. Separately, imem_ready held 0 with TIMEOUT=16 -> TRAP after 16 wait cycles, trap_cause=10; state stays 7 until reset.
- 0x022081B3 (mul): macro on, mdu_done after 5 cycles -> one mdu_start pulse, then WB with wb_sel=11. Macro off -> trap_cause=01.
